// File: rtl/vtg_pkg.sv
// Shared constants and helpers for the video timing generator.
// Pattern codes match the pattern_sel encoding.
package vtg_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] PAT_BARS   = 2'd0;
    localparam logic [1:0] PAT_RAMP   = 2'd1;
    localparam logic [1:0] PAT_CHECK  = 2'd2;
    localparam logic [1:0] PAT_SQUARE = 2'd3;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Combinational test pattern source: pixel coordinate, frame count and
// pattern code in, RGB out. Used only when VTG_TEST_PATTERN_EN is defined.
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [7:0]  fc,
    input  logic [1:0]  pat,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int BAR_SH = $clog2(IMG_W) - 3;
    // Guard the modulus so a minimal 8-pixel image does not divide by zero
    localparam int MOD_X = (IMG_W > 8) ? IMG_W - 8 : 1;
    localparam int MOD_Y = (IMG_H > 8) ? IMG_H - 8 : 1;

    logic [2:0]  bar_s;
    logic [10:0] sq_x_s;
    logic [10:0] sq_y_s;
    logic        in_sq_s;
    logic        check_s;

    assign bar_s   = 3'(x >> BAR_SH);
    assign sq_x_s  = 11'({3'b000, fc} % 11'(MOD_X));
    assign sq_y_s  = 11'({3'b000, fc} % 11'(MOD_Y));
    assign in_sq_s = (x >= sq_x_s) && ({1'b0, x} < ({1'b0, sq_x_s} + 12'd8)) &&
                     (y >= sq_y_s) && ({1'b0, y} < ({1'b0, sq_y_s} + 12'd8));
    assign check_s = x[3] ^ y[3];

    // Select the pattern colour for the current pixel
    always_comb begin
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        case (pat)
            PAT_BARS: begin
                r = {8{bar_s[2]}};
                g = {8{bar_s[1]}};
                b = {8{bar_s[0]}};
            end
            PAT_RAMP: begin
                r = x[7:0];
                g = x[7:0];
                b = x[7:0];
            end
            PAT_CHECK: begin
                r = {8{check_s}};
                g = {8{check_s}};
                b = {8{check_s}};
            end
            PAT_SQUARE: begin
                r = {8{in_sq_s}};
                g = {8{in_sq_s}};
                b = {8{in_sq_s}};
            end
            default: begin
                r = 8'h00;
                g = 8'h00;
                b = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator with registered de/hsync/vsync, coordinates and RGB.
// Define VTG_TEST_PATTERN_EN to build in the internal test pattern source.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int H_FP   = 4,
    parameter int H_SYNC = 8,
    parameter int H_BP   = 4,
    parameter int V_FP   = 2,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start
);

    localparam int H_TOTAL = calc_total(IMG_W, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(IMG_H, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(IMG_W + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(IMG_W + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(IMG_H + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(IMG_H + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic             h_last_s;
    logic             v_last_s;
    logic             active_s;
    logic             hs_s;
    logic             vs_s;
    logic             first_s;
    logic [7:0]       src_r_s;
    logic [7:0]       src_g_s;
    logic [7:0]       src_b_s;

    logic             de_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             frame_start_r;
    logic [10:0]      x_r;
    logic [10:0]      y_r;
    logic [7:0]       r_r;
    logic [7:0]       g_r;
    logic [7:0]       b_r;

    assign h_last_s = (h_cnt_r == H_LAST);
    assign v_last_s = (v_cnt_r == V_LAST);
    assign active_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    assign hs_s     = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
    assign vs_s     = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
    assign first_s  = (h_cnt_r == '0) && (v_cnt_r == '0);

    // Raster position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (ce) begin
            if (h_last_s) begin
                h_cnt_r <= '0;
                if (v_last_s) begin
                    v_cnt_r <= '0;
                end else begin
                    v_cnt_r <= v_cnt_r + CNT_W'(1);
                end
            end else begin
                h_cnt_r <= h_cnt_r + CNT_W'(1);
            end
        end
    end

`ifdef VTG_TEST_PATTERN_EN
    logic [1:0] pat_r;
    logic [1:0] pat_s;
    logic [7:0] fc_r;
    logic       unused_pix_s;

    assign unused_pix_s = ^{pix_r, pix_g, pix_b};
    // Bypass at (0,0) so the newly latched pattern covers the whole frame
    assign pat_s = first_s ? pattern_sel : pat_r;

    // Per-frame pattern latch and frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_r <= PAT_BARS;
            fc_r  <= 8'd0;
        end else if (ce) begin
            if (first_s) begin
                pat_r <= pattern_sel;
            end
            if (h_last_s && v_last_s) begin
                fc_r <= fc_r + 8'd1;
            end
        end
    end

    vtg_pattern #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pattern (
        .x   (h_cnt_r[10:0]),
        .y   (v_cnt_r[10:0]),
        .fc  (fc_r),
        .pat (pat_s),
        .r   (src_r_s),
        .g   (src_g_s),
        .b   (src_b_s)
    );
`else
    logic unused_pat_s;

    assign unused_pat_s = ^pattern_sel;
    assign src_r_s = pix_r;
    assign src_g_s = pix_g;
    assign src_b_s = pix_b;
`endif

    // Output register stage: one cycle behind the counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_r          <= 1'b0;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            frame_start_r <= 1'b0;
            x_r           <= 11'd0;
            y_r           <= 11'd0;
            r_r           <= 8'h00;
            g_r           <= 8'h00;
            b_r           <= 8'h00;
        end else if (ce) begin
            de_r          <= active_s;
            hsync_r       <= hs_s;
            vsync_r       <= vs_s;
            frame_start_r <= first_s;
            x_r           <= active_s ? h_cnt_r[10:0] : 11'd0;
            y_r           <= active_s ? v_cnt_r[10:0] : 11'd0;
            r_r           <= active_s ? src_r_s : 8'h00;
            g_r           <= active_s ? src_g_s : 8'h00;
            b_r           <= active_s ? src_b_s : 8'h00;
        end
    end

    assign de          = de_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = frame_start_r;
    assign x           = x_r;
    assign y           = y_r;
    assign r           = r_r;
    assign g           = g_r;
    assign b           = b_r;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Synthesizable video stream source: generates `de`/`hsync`/`vsync` timing plus RGB pixel data for the neuro_skin pipeline (`rgb2ycbcr` → `bin` → `centroid` → `visualize`). It drives the same parallel RGB interface that the HDMI output side consumes, so the processing chain runs on hardware without a file-driven source. It also exports pixel coordinates and a frame-start strobe for downstream debug.

## Interface
- `IMG_W`, 64: active pixels per line; power of 2, ≥ 8, ≤ 2047
- `IMG_H`, 64: active lines per frame; ≤ 2047
- `H_FP`, 4: horizontal front porch (cycles)
- `H_SYNC`, 8: hsync width (cycles), ≥ 1
- `H_BP`, 4: horizontal back porch (cycles)
- `V_FP`, 2: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines), ≥ 1
- `V_BP`, 2: vertical back porch (lines)
- `clk`  in  1  pixel clock
- `rst_n`  in  1  synchronous reset, active-low
- `ce`  in  1  clock enable; low freezes all state and outputs
- `pattern_sel`  in  2  test pattern select; sampled only at frame start
- `pix_r`, `pix_g`, `pix_b`  in  8 each  external pixel data (used when test pattern is compiled out)
- `de`  out  1  data enable, active-high
- `hsync`  out  1  horizontal sync, active-high
- `vsync`  out  1  vertical sync, active-high
- `r`, `g`, `b`  out  8 each  pixel data
- `x`, `y`  out  11 each  coordinate of the current pixel; valid when `de`=1
- `frame_start`  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- `H_TOTAL = IMG_W+H_FP+H_SYNC+H_BP`; `V_TOTAL = IMG_H+V_FP+V_SYNC+V_BP`.
- Counter `h_cnt` runs 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments when `h_cnt` wraps, and wraps to 0 after V_TOTAL-1. Both advance only when `ce`=1.
- Active region: `h_cnt < IMG_W` and `v_cnt < IMG_H`; `de`=1 there, 0 elsewhere.
- `hsync`=1 for `IMG_W+H_FP ≤ h_cnt < IMG_W+H_FP+H_SYNC`, on every line, including blanking lines.
- `vsync`=1 for `IMG_H+V_FP ≤ v_cnt < IMG_H+V_FP+V_SYNC`. Transitions are aligned to `h_cnt`=0.
- `x`/`y` equal `h_cnt`/`v_cnt` during active; they hold 0 outside active.
- `pattern_sel` is latched when `h_cnt`=0 and `v_cnt`=0. A mid-frame change takes effect on the next frame.
- An 8-bit frame counter increments at each frame wrap and wraps 255→0.
- Patterns:
  - 00: 8 vertical colour bars. Index = `x >> log2(IMG_W/8)`; bit2→R, bit1→G, bit0→B, each bit mapping to 0xFF/0x00.
  - 01: grey ramp, r=g=b=`x[7:0]`.
  - 10: 8×8 checkerboard, white when `x[3]^y[3]`, else black.
  - 11: white 8×8 square on black. Top-left corner is (`fc mod (IMG_W-8)`, `fc mod (IMG_H-8)`), where fc is the frame count. Intended as centroid stimulus.
- RGB is forced to 0 whenever `de`=0.

## Timing
- All outputs are registered and mutually aligned. Outputs reflect the counter state one cycle later (latency 1).
- Reset (`rst_n`=0 at a `clk` edge): counters, frame counter, and latched pattern go to 0. All outputs go to 0.
- Reset wins over `ce`. Asserting reset mid-frame restarts at (0,0) with no partial-frame flush.
- First cycle after reset release with `ce`=1: counters are at (0,0). On the next edge, `de`=1, `frame_start`=1, `x`=`y`=0.
- `ce`=0: counters, frame counter, and all outputs hold their values. `frame_start` is not re-issued while held.
- Frame period: H_TOTAL×V_TOTAL enabled cycles. Defaults: 80×70 = 5600.

## Configuration
- `VTG_TEST_PATTERN_EN` defined: the pattern generator is compiled in and `pix_r/g/b` are ignored.
- Not defined: `r/g/b` are `pix_r/g/b` registered with the same 1-cycle latency and masked by `de`. `pattern_sel` is ignored, and the frame counter and pattern logic are removed.

## Structure
- Package `vtg_pkg`: pattern encoding constants (`PAT_BARS`, `PAT_RAMP`, `PAT_CHECK`, `PAT_SQUARE`) and a function computing H_TOTAL/V_TOTAL from the parameters.
- Sub-module `vtg_pattern`: combinational x/y/frame-count/pattern → RGB. It is instantiated only under `VTG_TEST_PATTERN_EN`.

## Test plan
All scenarios use default parameters unless stated.
- Reset, release, `ce`=1, pattern 00:
  - `frame_start` and `de` rise 1 cycle after release.
  - `de` is high for 64 cycles per line and 64 lines per frame.
  - `frame_start` period is 5600 cycles.
- Sync check:
  - hsync rises at h_cnt 68 and is 8 cycles wide, every line.
  - vsync is high for lines 66–67 (160 cycles), rising at h_cnt=0.
- Pattern 00: x=0..7 → RGB 000000; x=8 → 0000FF; x=56..63 → FFFFFF. During blanking, RGB = 0.
- Pattern 11 over frames 0 and 1: the white region is x,y∈[0,7] in frame 0 and [1,8] in frame 1. A 64-pixel white count per frame is checked.
- Pattern change and `ce` freeze:
  - Switch `pattern_sel` 00→10 mid-frame: output remains bars until the next `frame_start`, then checkerboard (x=8,y=0 → FF).
  - `ce`=0 for 10 cycles: outputs are constant, and the frame period extends by 10.
- Reset at line 30: the next cycle after release restarts at (0,0) with `frame_start`=1. Without `VTG_TEST_PATTERN_EN`: `pix_*`=0x12/34/56 appears 1 cycle later during `de`, and 0 in blanking.
